// File: rtl/gauss_row_window.sv
// gauss_row_window
//   Horizontal sliding-window front end of the Gaussian filter. A raster pixel
//   stream is taken one line at a time into a KERNEL_SIZE tap window. The edge
//   pixel is replicated at both line borders. Each tap is multiplied by its
//   kernel coefficient, and one vector of products is emitted per input pixel.
//
//   Ports
//     clk_i         clock, rising edge
//     rst_i         asynchronous active-high reset
//     data_valid_i  input beat valid
//     data_i        pixel (unsigned, PIXEL_WIDTH)
//     sol_i         start of line, qualified by data_valid_i
//     eol_i         end of line, qualified by data_valid_i (may coincide with sol_i)
//     ready_o       input beats are accepted this cycle
//     data_valid_o  product vector valid (one cycle per vector)
//     data_o        data_o[k] = tap[k] * COEFS[k], held while data_valid_o is low
module gauss_row_window #(
  parameter int KERNEL_SIZE = 5,
  parameter int PIXEL_WIDTH = 8,
  parameter int COEF_WIDTH  = 8,
  parameter logic [KERNEL_SIZE-1:0][COEF_WIDTH-1:0] COEFS = {8'd1, 8'd4, 8'd6, 8'd4, 8'd1},
  parameter int PRODUCT_WIDTH = PIXEL_WIDTH + COEF_WIDTH
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      data_valid_i,
  input  logic [PIXEL_WIDTH-1:0]                    data_i,
  input  logic                                      sol_i,
  input  logic                                      eol_i,
  output logic                                      ready_o,
  output logic                                      data_valid_o,
  output logic [KERNEL_SIZE-1:0][PRODUCT_WIDTH-1:0] data_o
);

  localparam int HALF  = KERNEL_SIZE / 2;
  localparam int CNT_W = $clog2(HALF + 1);
  localparam logic [CNT_W-1:0] HALF_C       = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] FLUSH_LAST_C = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C   = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                                    state_q, state_d;
  logic [KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0]   win_q, win_d;
  logic [CNT_W-1:0]                          cnt_q, cnt_d;
  logic [CNT_W-1:0]                          flush_q, flush_d;
  logic                                      emit_q, emit_d;
  logic                                      data_valid_q;
  logic [KERNEL_SIZE-1:0][PRODUCT_WIDTH-1:0] data_q;
  logic [KERNEL_SIZE-1:0][PRODUCT_WIDTH-1:0] prod_s;

  logic                   ready_s;
  logic                   accept_s;
  logic                   refill_s;
  logic                   shift_s;
  logic [PIXEL_WIDTH-1:0] shift_px_s;

  // Input is refused only while the right border is being flushed.
  assign ready_s  = (state_q != ST_FLUSH);
  assign accept_s = data_valid_i && ready_s;

  // Next-state, window and counter update.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    emit_d     = 1'b0;
    refill_s   = 1'b0;
    shift_s    = 1'b0;
    shift_px_s = data_i;

    case (state_q)
      ST_IDLE: begin
        if (accept_s && sol_i) begin
          refill_s = 1'b1;
          flush_d  = CNT_ZERO_C;
          state_d  = eol_i ? ST_FLUSH : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && sol_i) begin
          // A new sol abandons the current line without flushing it.
          refill_s = 1'b1;
          flush_d  = CNT_ZERO_C;
          state_d  = eol_i ? ST_FLUSH : ST_RUN;
        end else if (accept_s) begin
          shift_s = 1'b1;
          flush_d = CNT_ZERO_C;
          state_d = eol_i ? ST_FLUSH : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Replicate the last pixel to finish the right border.
        shift_s    = 1'b1;
        shift_px_s = win_q[KERNEL_SIZE-1];
        if (flush_q == FLUSH_LAST_C) begin
          state_d = ST_IDLE;
          flush_d = CNT_ZERO_C;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        flush_d = CNT_ZERO_C;
      end
    endcase

    if (refill_s) begin
      // Filling every tap with the first pixel replicates the left border.
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        win_d[k] = data_i;
      end
      cnt_d = CNT_ZERO_C;
    end else if (shift_s) begin
      for (int k = 0; k < KERNEL_SIZE - 1; k++) begin
        win_d[k] = win_q[k+1];
      end
      win_d[KERNEL_SIZE-1] = shift_px_s;
      cnt_d  = (cnt_q == HALF_C) ? cnt_q : cnt_q + 1'b1;
      // The counter saturates, so reaching HALF is the same as cnt >= HALF.
      emit_d = (cnt_d == HALF_C);
    end else begin
      emit_d = 1'b0;
    end
  end

  // Tap products of the current window.
  always_comb begin
    prod_s = {(KERNEL_SIZE * PRODUCT_WIDTH){1'b0}};
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      prod_s[k] = PRODUCT_WIDTH'(win_q[k]) * PRODUCT_WIDTH'(COEFS[k]);
    end
  end

  // Control state, window and emit flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      win_q   <= {(KERNEL_SIZE * PIXEL_WIDTH){1'b0}};
      cnt_q   <= CNT_ZERO_C;
      flush_q <= CNT_ZERO_C;
      emit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      emit_q  <= emit_d;
    end
  end

  // Output product register; holds its value between vectors.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_valid_q <= 1'b0;
      data_q       <= {(KERNEL_SIZE * PRODUCT_WIDTH){1'b0}};
    end else begin
      data_valid_q <= emit_q;
      if (emit_q) begin
        data_q <= prod_s;
      end else begin
        data_q <= data_q;
      end
    end
  end

  assign ready_o      = ready_s;
  assign data_valid_o = data_valid_q;
  assign data_o       = data_q;

endmodule
